// File: rtl/usb_fifo_pkg.sv
// Shared constants for the USB slave-FIFO bridge model.
// Holds the endpoint addresses and the default bus width, FIFO depth and packet size.
// No ports; imported by usb_fifo_model and sync_fifo_core.
package usb_fifo_pkg;

  localparam int         DEF_DATA_W   = 16;
  localparam int         DEF_DEPTH    = 256;
  localparam int         DEF_PKT_SIZE = 256;

  // USB_ADDR codes for the two endpoints used by this model.
  localparam logic [1:0] OUT_EP_ADDR  = 2'b00;
  localparam logic [1:0] IN_EP_ADDR   = 2'b10;

endpackage

// File: rtl/sync_fifo_core.sv
// Dual-pointer synchronous FIFO with occupancy count and optional packet-commit pointer.
// Latency: first-word-fall-through head, pointers and counts update on the clock edge.
// Backpressure: writes when full and reads when nothing is readable are silently dropped.
// Ports: clk/rst_n; wr_en/wr_data push; rd_en pops; cmt_req commits all uncommitted words;
//        rd_data head word; full; count total occupancy; avail readable words; pkt_done commit pulse.
module sync_fifo_core
  import usb_fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PKT_SIZE   = DEF_PKT_SIZE,
  parameter bit HAS_COMMIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic                       cmt_req,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     avail,
  output logic                       pkt_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PKT_LVL = CW'(PKT_SIZE);

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cmt_ptr_q, cmt_ptr_d;
  logic [CW-1:0]     vis_ptr;
  logic [CW-1:0]     uncmt_next;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  // Without commit tracking every written word is immediately readable.
  assign vis_ptr = HAS_COMMIT ? cmt_ptr_q : wr_ptr_q;
  assign avail   = vis_ptr - rd_ptr_q;
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && (avail != '0);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    // Uncommitted count including a push on this edge, so a same-edge commit keeps that word.
    uncmt_next = wr_ptr_d - cmt_ptr_q;
    pkt_done   = 1'b0;
    if (HAS_COMMIT) begin
      pkt_done = (uncmt_next == PKT_LVL) || (cmt_req && (uncmt_next != '0));
    end
    cmt_ptr_d  = pkt_done ? wr_ptr_d : cmt_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cmt_ptr_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/usb_fifo_model.sv
// Behavioural model of a USB slave-FIFO bridge: OUT FIFO (host->FPGA) and packetised IN FIFO (FPGA->host).
// Latency: USB_DATA is fall-through from the OUT head; flags lag pointers by one cycle; HOST_RD_DATA one cycle after pop.
// Backpressure: strobes against an empty/full FIFO are dropped; host sees HOST_OUT_FULL and HOST_IN_AVAIL.
// Ports: USB_IFCLK/USB_RST_N; USB_ADDR, USB_SLRD, USB_SLWR, USB_SLOE, USB_PKEND strobes (active-low);
//        USB_DATA bus; USB_FLAGA/B/D status; HOST_WR_* preload OUT; HOST_RD_*, HOST_IN_AVAIL, HOST_IN_PKTS drain IN.
module usb_fifo_model
  import usb_fifo_pkg::*;
#(
  parameter int         DATA_W    = DEF_DATA_W,
  parameter int         DEPTH     = DEF_DEPTH,
  parameter int         PKT_SIZE  = DEF_PKT_SIZE,
  parameter int         PF_THRESH = DEPTH - 4,
  parameter logic [1:0] OUT_EP    = OUT_EP_ADDR,
  parameter logic [1:0] IN_EP     = IN_EP_ADDR
) (
  input  logic                       USB_IFCLK,
  input  logic                       USB_RST_N,
  input  logic [1:0]                 USB_ADDR,
  input  logic                       USB_SLRD,
  input  logic                       USB_SLWR,
  input  logic                       USB_SLOE,
  input  logic                       USB_PKEND,
  inout  wire  [DATA_W-1:0]          USB_DATA,
  output logic                       USB_FLAGA,
  output logic                       USB_FLAGB,
  output logic                       USB_FLAGD,
  input  logic                       HOST_WR_EN,
  input  logic [DATA_W-1:0]          HOST_WR_DATA,
  output logic                       HOST_OUT_FULL,
  input  logic                       HOST_RD_EN,
  output logic [DATA_W-1:0]          HOST_RD_DATA,
  output logic [$clog2(DEPTH):0]     HOST_IN_AVAIL,
  output logic [15:0]                HOST_IN_PKTS
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] PF_LVL = CW'(PF_THRESH);

  logic              out_sel, in_sel;
  logic              usb_oe, usb_rd, usb_wr, usb_pkend;
  logic              host_rd_ok;

  logic [DATA_W-1:0] out_head, in_head;
  logic              out_full, in_full;
  logic [CW-1:0]     out_count, out_avail, in_count, in_avail;
  logic              out_pkt_done, in_pkt_done;
  logic              unused_out;

  logic              flaga_q, flaga_d;
  logic              flagb_q, flagb_d;
  logic              flagd_q, flagd_d;
  logic [DATA_W-1:0] host_rd_data_q, host_rd_data_d;
  logic [15:0]       in_pkts_q, in_pkts_d;

  assign out_sel   = (USB_ADDR == OUT_EP);
  assign in_sel    = (USB_ADDR == IN_EP);
  assign usb_oe    = !USB_SLOE && out_sel;
  assign usb_rd    = usb_oe && !USB_SLRD;
  assign usb_wr    = in_sel && !USB_SLWR;
  assign usb_pkend = in_sel && !USB_PKEND;
  // The host may only take words that belong to a committed packet.
  assign host_rd_ok = HOST_RD_EN && (in_avail != '0);

  assign USB_DATA = usb_oe ? out_head : {DATA_W{1'bz}};

  sync_fifo_core #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .PKT_SIZE   (PKT_SIZE),
    .HAS_COMMIT (1'b0)
  ) u_out_fifo (
    .clk      (USB_IFCLK),
    .rst_n    (USB_RST_N),
    .wr_en    (HOST_WR_EN),
    .wr_data  (HOST_WR_DATA),
    .rd_en    (usb_rd),
    .cmt_req  (1'b0),
    .rd_data  (out_head),
    .full     (out_full),
    .count    (out_count),
    .avail    (out_avail),
    .pkt_done (out_pkt_done)
  );

  sync_fifo_core #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .PKT_SIZE   (PKT_SIZE),
    .HAS_COMMIT (1'b1)
  ) u_in_fifo (
    .clk      (USB_IFCLK),
    .rst_n    (USB_RST_N),
    .wr_en    (usb_wr),
    .wr_data  (USB_DATA),
    .rd_en    (host_rd_ok),
    .cmt_req  (usb_pkend),
    .rd_data  (in_head),
    .full     (in_full),
    .count    (in_count),
    .avail    (in_avail),
    .pkt_done (in_pkt_done)
  );

  // OUT count equals OUT avail (no commit stage) and the OUT FIFO never commits packets.
  assign unused_out = ^{out_avail, out_pkt_done};

  always_comb begin
    flaga_d        = (out_count != '0);
    flagb_d        = (in_count >= PF_LVL);
    flagd_d        = !in_full;
    host_rd_data_d = host_rd_ok ? in_head : host_rd_data_q;
    in_pkts_d      = in_pkt_done ? (in_pkts_q + 16'd1) : in_pkts_q;
  end

  always_ff @(posedge USB_IFCLK or negedge USB_RST_N) begin
    if (!USB_RST_N) begin
      flaga_q        <= 1'b0;
      flagb_q        <= 1'b0;
      flagd_q        <= 1'b1;
      host_rd_data_q <= '0;
      in_pkts_q      <= '0;
    end else begin
      flaga_q        <= flaga_d;
      flagb_q        <= flagb_d;
      flagd_q        <= flagd_d;
      host_rd_data_q <= host_rd_data_d;
      in_pkts_q      <= in_pkts_d;
    end
  end

  assign USB_FLAGA     = flaga_q;
  assign USB_FLAGB     = flagb_q;
  assign USB_FLAGD     = flagd_q;
  assign HOST_OUT_FULL = out_full;
  assign HOST_RD_DATA  = host_rd_data_q;
  assign HOST_IN_AVAIL = in_avail;
  assign HOST_IN_PKTS  = in_pkts_q;

endmodule

// File: tb/tb_usb_fifo_model.sv
// Directed bench for usb_fifo_model: a default instance (DEPTH 256) and a DEPTH 8 instance share stimulus.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Each comparison is an immediate assertion that counts and reports its failure.
module tb_usb_fifo_model;

  logic        clk;
  logic        rst_n;
  logic [1:0]  addr;
  logic        slrd, slwr, sloe, pkend;
  logic        tb_oe;
  logic [15:0] tb_dat;
  logic        host_wr_en, host_rd_en;
  logic [15:0] host_wr_data;

  wire  [15:0] usb_data_a, usb_data_b;
  logic        flaga_a, flagb_a, flagd_a, out_full_a;
  logic        flaga_b, flagb_b, flagd_b, out_full_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [8:0]  avail_a;
  logic [3:0]  avail_b;
  logic [15:0] pkts_a, pkts_b;

  int n_assert = 0;
  int n_fail   = 0;

  assign usb_data_a = tb_oe ? tb_dat : 16'hzzzz;
  assign usb_data_b = tb_oe ? tb_dat : 16'hzzzz;

  usb_fifo_model dut_a (
    .USB_IFCLK(clk), .USB_RST_N(rst_n), .USB_ADDR(addr),
    .USB_SLRD(slrd), .USB_SLWR(slwr), .USB_SLOE(sloe), .USB_PKEND(pkend),
    .USB_DATA(usb_data_a),
    .USB_FLAGA(flaga_a), .USB_FLAGB(flagb_a), .USB_FLAGD(flagd_a),
    .HOST_WR_EN(host_wr_en), .HOST_WR_DATA(host_wr_data), .HOST_OUT_FULL(out_full_a),
    .HOST_RD_EN(host_rd_en), .HOST_RD_DATA(rd_data_a),
    .HOST_IN_AVAIL(avail_a), .HOST_IN_PKTS(pkts_a)
  );

  usb_fifo_model #(.DEPTH(8), .PKT_SIZE(8)) dut_b (
    .USB_IFCLK(clk), .USB_RST_N(rst_n), .USB_ADDR(addr),
    .USB_SLRD(slrd), .USB_SLWR(slwr), .USB_SLOE(sloe), .USB_PKEND(pkend),
    .USB_DATA(usb_data_b),
    .USB_FLAGA(flaga_b), .USB_FLAGB(flagb_b), .USB_FLAGD(flagd_b),
    .HOST_WR_EN(host_wr_en), .HOST_WR_DATA(host_wr_data), .HOST_OUT_FULL(out_full_b),
    .HOST_RD_EN(host_rd_en), .HOST_RD_DATA(rd_data_b),
    .HOST_IN_AVAIL(avail_b), .HOST_IN_PKTS(pkts_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    addr = 2'b01; slrd = 1'b1; slwr = 1'b1; sloe = 1'b1; pkend = 1'b1;
    tb_oe = 1'b1; tb_dat = 16'h0;
    host_wr_en = 1'b0; host_wr_data = 16'h0; host_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pushes n words base+i into the IN endpoint; PKEND rides on the last push when requested.
  task automatic usb_push(input int n, input logic [15:0] base, input bit end_pkt);
    for (int i = 0; i < n; i++) begin
      addr = 2'b10; slwr = 1'b0; tb_dat = base + 16'(i);
      pkend = (end_pkt && (i == n - 1)) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    slwr = 1'b1; pkend = 1'b1; addr = 2'b01;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_flaga", flaga_a, 0);
    chk("rst_flagb", flagb_a, 0);
    chk("rst_flagd", flagd_a, 1);
    chk("rst_out_full", out_full_a, 0);
    chk("rst_rd_data", rd_data_a, 0);
    chk("rst_avail", avail_a, 0);
    chk("rst_pkts", pkts_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // OUT path: preload 0..4, read back fall-through, flag falls one cycle late
    for (int i = 0; i < 5; i++) begin
      host_wr_en = 1'b1; host_wr_data = 16'(i);
      @(negedge clk);
    end
    host_wr_en = 1'b0;
    chk("out_flaga_set", flaga_a, 1);
    tb_oe = 1'b0; addr = 2'b00; sloe = 1'b0; slrd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("out_data_%0d", i), usb_data_a, i);
      @(negedge clk);
    end
    chk("out_flaga_stale", flaga_a, 1);
    @(negedge clk);
    chk("out_flaga_clear", flaga_a, 0);
    // The stale-flag read above must have been dropped: a fresh word becomes the head.
    slrd = 1'b1; host_wr_en = 1'b1; host_wr_data = 16'h0055;
    @(negedge clk);
    host_wr_en = 1'b0;
    #1;
    chk("out_drop_empty_read", usb_data_a, 16'h0055);
    slrd = 1'b0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    // IN path: 3 words with PKEND on the third edge
    usb_push(2, 16'h00A0, 1'b0);
    chk("in_uncommitted_avail", avail_a, 0);
    usb_push(1, 16'h00A2, 1'b1);
    chk("pkend_pkts", pkts_a, 1);
    chk("pkend_avail", avail_a, 3);
    addr = 2'b10; pkend = 1'b0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("lone_pkend_pkts", pkts_a, 1);
    for (int i = 0; i < 3; i++) begin
      host_rd_en = 1'b1;
      @(negedge clk);
      chk($sformatf("pkend_rd_%0d", i), rd_data_a, 16'h00A0 + 16'(i));
    end
    host_rd_en = 1'b0;
    chk("pkend_drained", avail_a, 0);

    // Full packet auto-commit and dropped overflow push
    do_reset();
    usb_push(255, 16'h0000, 1'b0);
    chk("auto_pre_avail", avail_a, 0);
    usb_push(1, 16'd255, 1'b0);
    @(negedge clk);
    chk("auto_pkts", pkts_a, 1);
    chk("auto_avail", avail_a, 256);
    chk("auto_flagd", flagd_a, 0);
    chk("auto_flagb", flagb_a, 1);
    usb_push(1, 16'hBEEF, 1'b0);
    chk("overflow_avail", avail_a, 256);
    chk("overflow_pkts", pkts_a, 1);
    for (int i = 0; i < 256; i++) begin
      host_rd_en = 1'b1;
      @(negedge clk);
      chk($sformatf("auto_rd_%0d", i), rd_data_a, i);
    end
    host_rd_en = 1'b0;
    @(negedge clk);
    chk("auto_drained", avail_a, 0);
    chk("auto_flagd_back", flagd_a, 1);

    // Asynchronous reset mid-packet
    usb_push(10, 16'h0300, 1'b0);
    chk("mid_pkt_avail", avail_a, 0);
    chk("mid_pkt_pkts", pkts_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_avail", avail_a, 0);
    chk("arst_pkts", pkts_a, 0);
    chk("arst_flagd", flagd_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    usb_push(2, 16'h0400, 1'b1);
    chk("post_rst_avail", avail_a, 2);
    chk("post_rst_pkts", pkts_a, 1);
    host_rd_en = 1'b1;
    @(negedge clk);
    host_rd_en = 1'b0;
    chk("post_rst_rd", rd_data_a, 16'h0400);

    // DEPTH 8 instance: threshold flag and pointer wrap
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      usb_push(6, 16'(rep * 16), 1'b1);
      @(negedge clk);
      chk($sformatf("wrap_flagb_hi_%0d", rep), flagb_b, 1);
      chk($sformatf("wrap_avail_%0d", rep), avail_b, 6);
      for (int i = 0; i < 6; i++) begin
        host_rd_en = 1'b1;
        @(negedge clk);
        chk($sformatf("wrap_rd_%0d_%0d", rep, i), rd_data_b, rep * 16 + i);
      end
      host_rd_en = 1'b0;
      @(negedge clk);
      chk($sformatf("wrap_flagb_lo_%0d", rep), flagb_b, 0);
      chk($sformatf("wrap_flagd_%0d", rep), flagd_b, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_fifo_model.md
USB_FIFO_MODEL -- requirements
Module: usb_fifo_model

Interface
REQ-001 Parameter DATA_W, 16, USB_DATA width in bits; legal values are 8 and 16.
REQ-002 Parameter DEPTH, 256, words per endpoint FIFO; power of 2, at least 4.
REQ-003 Parameter PKT_SIZE, 256, IN words per auto-committed packet; at most DEPTH.
REQ-004 Parameter PF_THRESH, DEPTH-4, IN occupancy at or above which USB_FLAGB is high.
REQ-005 Parameter OUT_EP, 2'b00, USB_ADDR value that selects the OUT (host->FPGA) FIFO.
REQ-006 Parameter IN_EP, 2'b10, USB_ADDR value that selects the IN (FPGA->host) FIFO.
REQ-007 USB_IFCLK  in  1  sole clock; all logic is on its rising edge.
REQ-008 USB_RST_N  in  1  reset; asynchronous, active-low.
REQ-009 USB_ADDR  in  2  endpoint select.
REQ-010 USB_SLRD  in  1  active-low read strobe.
REQ-011 USB_SLWR  in  1  active-low write strobe.
REQ-012 USB_SLOE  in  1  active-low output enable.
REQ-013 USB_PKEND  in  1  active-low packet end for the IN FIFO.
REQ-014 USB_DATA  inout  DATA_W  bidirectional data bus.
REQ-015 USB_FLAGA  out  1  high = OUT FIFO not empty.
REQ-016 USB_FLAGB  out  1  high = IN FIFO at or above PF_THRESH.
REQ-017 USB_FLAGD  out  1  high = IN FIFO not full.
REQ-018 HOST_WR_EN, HOST_WR_DATA[DATA_W], HOST_OUT_FULL: inputs and output that preload the OUT FIFO.
REQ-019 HOST_RD_EN, HOST_RD_DATA[DATA_W], HOST_IN_AVAIL[log2(DEPTH)+1]: inputs and outputs that drain committed IN words.
REQ-020 HOST_IN_PKTS  out  16  number of IN packets committed since reset; wraps at 2^16.

Function
REQ-021 USB_DATA is driven with the OUT FIFO head word (first-word-fall-through) when USB_SLOE=0 and USB_ADDR=OUT_EP; otherwise it is high-Z.
REQ-022 OUT pop: USB_SLRD=0 and USB_SLOE=0 and USB_ADDR=OUT_EP and OUT FIFO internally non-empty; the pointer advances one word per edge.
REQ-023 IN push: USB_SLWR=0 and USB_ADDR=IN_EP and IN FIFO internally not full; USB_DATA is captured on that edge.
REQ-024 A strobe against an internally empty FIFO (read) or full FIFO (write) is dropped with no pointer change, even when the registered flag is stale.
REQ-025 USB_FLAGA, USB_FLAGB and USB_FLAGD are registered and reflect occupancy one cycle after the pointer change (1-cycle flag latency).
REQ-026 Written IN words are uncommitted; they are committed, and HOST_IN_PKTS increments, when the uncommitted count reaches PKT_SIZE.
REQ-027 USB_PKEND=0 with USB_ADDR=IN_EP commits all uncommitted words.
REQ-028 PKEND and a push on the same edge: the pushed word is included in the packet, which is committed on that edge.
REQ-029 PKEND with zero uncommitted words is ignored; HOST_IN_PKTS does not change.
REQ-030 HOST_RD_EN pops a word only when HOST_IN_AVAIL (committed count) > 0; HOST_RD_DATA is valid the cycle after the pop.
REQ-031 HOST_WR_EN is ignored while HOST_OUT_FULL=1.
REQ-032 A simultaneous host push and USB pop on the OUT FIFO both take effect; occupancy is unchanged.
REQ-033 Pointers are log2(DEPTH)+1 bits; full and empty are derived from the MSB-differing compare; the pointers wrap without loss.

Reset
REQ-034 USB_RST_N=0 asynchronously clears all pointers, counts and HOST_IN_PKTS to 0 and discards uncommitted data.
REQ-035 Reset values: USB_FLAGA=0, USB_FLAGB=0, USB_FLAGD=1, HOST_OUT_FULL=0, HOST_RD_DATA=0, USB_DATA high-Z.
REQ-036 Reset asserted mid-packet drops the partial packet; after release the first push starts a new packet.

Structure
REQ-037 Package usb_fifo_pkg holds OUT_EP and IN_EP constants and the default DATA_W, DEPTH and PKT_SIZE values.
REQ-038 Sub-module sync_fifo_core (dual-pointer synchronous FIFO with count) is instantiated twice; the IN instance adds the commit pointer.

Verification
REQ-039 Preload 5 words 0..4 and read with SLOE=0, SLRD=0, ADDR=00 -> USB_DATA sequence 0,1,2,3,4; FLAGA falls one cycle after the 5th pop.
REQ-040 Push 256 words to IN_EP with PKT_SIZE=256 -> HOST_IN_PKTS=1, HOST_IN_AVAIL=256, FLAGD=0; a 257th push is dropped.
REQ-041 Push 3 words, then PKEND=0 on the 3rd push edge -> HOST_IN_PKTS=1, HOST_IN_AVAIL=3; a later lone PKEND leaves HOST_IN_PKTS=1.
REQ-042 DEPTH=8: push 6 words -> FLAGB=1 (PF_THRESH=4); host drains 6 words -> FLAGB=0 and FLAGD=1; repeat 3 times -> data intact across pointer wrap.
REQ-043 Assert USB_RST_N=0 after 10 pushes without a commit -> HOST_IN_AVAIL=0, HOST_IN_PKTS=0, FLAGD=1 immediately, asynchronously.
